cdb_writeback: RTL
==================

// Module: cdb_writeback
// PURPOSE
// - Result-consumer side of the execute stage: accepts one {tag, value} result per cycle from execute and
//   queues it in a DEPTH-entry FIFO.
// - Broadcasts the oldest queued result on the common data bus (CDB) to the reservation stations and ROB.
// - Absorbs CDB stalls via in_ready backpressure; flush discards all queued results on mispredict.
// PARAMETERS
// - DEPTH   4   FIFO entries; power of 2, >= 2
// - TAG_W   5   ROB tag width
// - DATA_W  32  result width
// PORTS
// - clk        in   1                  clock, rising edge
// - rst_n      in   1                  asynchronous reset, active-low
// - flush      in   1                  discard all queued results (sync, priority over all else)
// - in_valid   in   1                  execute presents a result
// - in_ready   out  1                  FIFO can accept; transfer when in_valid & in_ready
// - in_tag     in   TAG_W              destination ROB tag of result
// - in_value   in   DATA_W             result value (execute value_out)
// - cdb_valid  out  1                  CDB broadcast valid
// - cdb_ready  in   1                  ROB/RS consume broadcast; transfer when cdb_valid & cdb_ready
// - cdb_tag    out  TAG_W              broadcast tag
// - cdb_value  out  DATA_W             broadcast value
// - level      out  $clog2(DEPTH)+1    current FIFO occupancy
// BEHAVIOUR
// - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0; cdb_valid=0, cdb_tag=0, cdb_value=0, level=0,
//   in_ready=1 after reset release. Storage array not reset. Reset mid-operation drops all entries.
// - Storage: DEPTH flop entries, pointers $clog2(DEPTH) bits, wrap modulo DEPTH naturally.
// - push = in_valid & in_ready & !flush; pop = cdb_valid & cdb_ready & !flush.
// - in_ready = (count != DEPTH); registered-state only, no combinational path from cdb_ready.
// - cdb_valid = (count != 0); cdb_tag/cdb_value = entry[rd_ptr] (flop outputs, no comb logic from inputs).
// - Latency: result pushed in cycle N is visible on CDB in N+1 when FIFO was empty.
// - Ordering: strict FIFO; results broadcast in acceptance order.
// - Stall: while cdb_valid & !cdb_ready, cdb_tag/cdb_value/cdb_valid held stable.
// - push & pop same cycle: both pointers advance, count unchanged (legal at any count 1..DEPTH-1;
//   at count==DEPTH in_ready=0 so no push; at count==0 no pop).
// - Full: count==DEPTH -> in_ready=0; in_valid ignored, execute must hold result.
// - Empty: count==0 -> cdb_valid=0; cdb_ready ignored.
// - flush=1: next cycle count=0, wr_ptr=rd_ptr=0, cdb_valid=0; input offered that cycle is dropped
//   (not accepted even if in_ready=1); pop that cycle does not occur.
// - level = count, updated same edge as pointers.
// CONFIGURATION
// - CDB_BYPASS_EN defined: when count==0 and in_valid & !flush, result drives CDB combinationally
//   same cycle (cdb_valid=1, cdb_tag=in_tag, cdb_value=in_value); if cdb_ready=1 it is consumed and
//   not written; if cdb_ready=0 it is written as normal push. Zero-cycle latency on empty path.
// - CDB_BYPASS_EN undefined: no bypass; minimum latency 1 cycle; CDB outputs purely from flops.
// TESTING
// - Reset: rst_n=0 mid-traffic with 3 entries -> cdb_valid=0, level=0 immediately (async); in_ready=1.
// - Single result: push tag=3 value=0xDEADBEEF, cdb_ready=1 -> cdb shows tag 3/0xDEADBEEF next
//   cycle (same cycle with CDB_BYPASS_EN), level returns to 0.
// - Fill/backpressure: DEPTH=4, cdb_ready=0, push tags 1..5 -> tags 1..4 accepted, in_ready=0 at
//   level 4, tag 5 held; release cdb_ready -> broadcast 1,2,3,4,5 in order, cdb stable while stalled.
// - Simultaneous: level 2, push+pop every cycle for 10 cycles across pointer wrap -> level stays 2,
//   output order matches input order.
// - Flush: level 3, flush=1 with in_valid=1 tag 7 -> next cycle level=0, cdb_valid=0, tag 7 never
//   broadcast.
// - Random: constrained-random in_valid/cdb_ready 10k cycles vs queue scoreboard -> no loss/dup/reorder.

Source files
------------

// File: rtl/cdb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : cdb_writeback
// Description : Execute-result FIFO that broadcasts the oldest result on the
//               common data bus. Optional same-cycle empty-path bypass is
//               enabled by defining CDB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_writeback #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [DATA_W-1:0]       in_value,
    output logic                    cdb_valid,
    input  logic                    cdb_ready,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_value,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [TAG_W-1:0]   r_tag_mem   [DEPTH];
    logic [DATA_W-1:0]  r_value_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_FULL);
    assign in_ready = !w_full;
    assign level    = r_count;
    assign w_pop    = !w_empty & cdb_ready & !flush;

`ifdef CDB_BYPASS_EN
    logic w_bypass;

    // An empty FIFO forwards the incoming result straight onto the bus; it is
    // only stored when the bus does not take it this cycle.
    assign w_bypass  = w_empty & in_valid & !flush;
    assign w_push    = in_valid & !w_full & !flush & !(w_bypass & cdb_ready);
    assign cdb_valid = !w_empty | w_bypass;
    assign cdb_tag   = w_bypass ? in_tag   : (w_empty ? '0 : r_tag_mem[r_rd_ptr]);
    assign cdb_value = w_bypass ? in_value : (w_empty ? '0 : r_value_mem[r_rd_ptr]);
`else
    assign w_push    = in_valid & !w_full & !flush;
    assign cdb_valid = !w_empty;
    assign cdb_tag   = w_empty ? '0 : r_tag_mem[r_rd_ptr];
    assign cdb_value = w_empty ? '0 : r_value_mem[r_rd_ptr];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is intentionally left unreset; emptiness gates the outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr]   <= in_tag;
            r_value_mem[r_wr_ptr] <= in_value;
        end
    end

endmodule
`default_nettype wire
